// File: rtl/mem_arbiter_if.sv
// Requester and engine signals of the RAM-engine arbiter.
// slave = arbiter side, master = requesters / engine / control side.
interface mem_arbiter_if;
    logic        rdy_in;
    logic        roll_back;
    logic        io_buffer_full;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [1:0]  ld_size;
    logic        ld_done;
    logic [31:0] ld_data;
    logic        st_req;
    logic [31:0] st_addr;
    logic [1:0]  st_size;
    logic [31:0] st_data;
    logic        st_done;
    logic        eng_valid;
    logic        eng_rw;
    logic [31:0] eng_addr;
    logic [4:0]  eng_len;
    logic [31:0] eng_wdata;
    logic        eng_abort;
    logic        eng_ready;
    logic        eng_done;
    logic [31:0] eng_rdata;

    modport slave (
        input  rdy_in, roll_back, io_buffer_full,
        input  if_req, if_addr, ld_req, ld_addr, ld_size,
        input  st_req, st_addr, st_size, st_data,
        input  eng_ready, eng_done, eng_rdata,
        output if_done, ld_done, ld_data, st_done,
        output eng_valid, eng_rw, eng_addr, eng_len, eng_wdata, eng_abort
    );

    modport master (
        output rdy_in, roll_back, io_buffer_full,
        output if_req, if_addr, ld_req, ld_addr, ld_size,
        output st_req, st_addr, st_size, st_data,
        output eng_ready, eng_done, eng_rdata,
        input  if_done, ld_done, ld_data, st_done,
        input  eng_valid, eng_rw, eng_addr, eng_len, eng_wdata, eng_abort
    );
endinterface

// File: rtl/mem_arbiter.sv
// Request-level arbiter in front of the byte-serial RAM engine (store > load > fetch).
// Optional fetch anti-starvation aging is enabled by defining ARB_AGE_EN.
//
// state  | meaning
// IDLE   | choose a winner among eligible requesters, latch its command
// ISSUE  | wait for eng_ready, then strobe eng_valid for one cycle
// BUSY   | wait for eng_done (or abort a flushed load/fetch)
// RESP   | winner's done pulse is high this cycle
module mem_arbiter #(
    parameter int ICACHE_BLK_SIZE = 16,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic         clk,
    input  logic         rst_in,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_t;
    typedef enum logic [1:0] {G_NONE, G_IF, G_LD, G_ST} grant_t;

    localparam logic [31:0] BLK_MASK = ~(32'(ICACHE_BLK_SIZE) - 32'd1);
    localparam logic [4:0]  BLK_LEN  = 5'(ICACHE_BLK_SIZE);

    state_t      state_q, state_d;
    grant_t      grant_q, grant_d;
    logic        eng_valid_q, eng_valid_d;
    logic        eng_rw_q, eng_rw_d;
    logic [31:0] eng_addr_q, eng_addr_d;
    logic [4:0]  eng_len_q, eng_len_d;
    logic [31:0] eng_wdata_q, eng_wdata_d;
    logic        eng_abort_q, eng_abort_d;
    logic        if_done_q, if_done_d;
    logic        ld_done_q, ld_done_d;
    logic        st_done_q, st_done_d;
    logic [31:0] ld_data_q, ld_data_d;

`ifdef ARB_AGE_EN
    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    logic [SW-1:0] starve_q, starve_d;
`endif

    logic   st_elig, ld_elig, if_elig, force_if, flush_kill;
    grant_t win;

    function automatic logic [4:0] size_len(input logic [1:0] sz);
        case (sz)
            2'b01:   return 5'd1;
            2'b10:   return 5'd2;
            default: return 5'd4;
        endcase
    endfunction

    function automatic logic [31:0] zext(input logic [31:0] d, input logic [4:0] len);
        case (len)
            5'd1:    return {24'd0, d[7:0]};
            5'd2:    return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    // IO-space stores wait while the UART buffer is full; a flush blocks speculative traffic.
    always_comb begin
        st_elig = bus.st_req && (bus.st_size != 2'b00) &&
                  !((bus.st_addr[17:16] == 2'b11) && bus.io_buffer_full);
        ld_elig = bus.ld_req && (bus.ld_size != 2'b00) && !bus.roll_back;
        if_elig = bus.if_req && !bus.roll_back;
`ifdef ARB_AGE_EN
        force_if = if_elig && (starve_q == STARVE_MAX);
`else
        force_if = 1'b0;
`endif
        if (force_if)     win = G_IF;
        else if (st_elig) win = G_ST;
        else if (ld_elig) win = G_LD;
        else if (if_elig) win = G_IF;
        else              win = G_NONE;
        flush_kill = bus.roll_back && ((grant_q == G_LD) || (grant_q == G_IF));
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        eng_valid_d = 1'b0;
        eng_rw_d    = eng_rw_q;
        eng_addr_d  = eng_addr_q;
        eng_len_d   = eng_len_q;
        eng_wdata_d = eng_wdata_q;
        eng_abort_d = 1'b0;
        if_done_d   = 1'b0;
        ld_done_d   = 1'b0;
        st_done_d   = 1'b0;
        ld_data_d   = ld_data_q;
`ifdef ARB_AGE_EN
        starve_d    = starve_q;
`endif
        case (state_q)
            S_IDLE: begin
                case (win)
                    G_IF: begin
                        eng_rw_d   = 1'b0;
                        eng_addr_d = bus.if_addr & BLK_MASK;
                        eng_len_d  = BLK_LEN;
                    end
                    G_LD: begin
                        eng_rw_d   = 1'b0;
                        eng_addr_d = bus.ld_addr;
                        eng_len_d  = size_len(bus.ld_size);
                    end
                    G_ST: begin
                        eng_rw_d    = 1'b1;
                        eng_addr_d  = bus.st_addr;
                        eng_len_d   = size_len(bus.st_size);
                        eng_wdata_d = bus.st_data;
                    end
                    default: ;
                endcase
                if (win != G_NONE) begin
                    grant_d = win;
                    state_d = S_ISSUE;
                end
`ifdef ARB_AGE_EN
                if (win == G_IF)
                    starve_d = '0;
                else if (if_elig && (win != G_NONE) && (starve_q != STARVE_MAX))
                    starve_d = starve_q + 1'b1;
`endif
            end
            S_ISSUE: begin
                if (flush_kill) begin
                    grant_d = G_NONE;
                    state_d = S_IDLE;
                end else if (bus.eng_ready) begin
                    eng_valid_d = 1'b1;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush_kill) begin
                    eng_abort_d = 1'b1;
                    grant_d     = G_NONE;
                    state_d     = S_IDLE;
                end else if (bus.eng_done) begin
                    if (grant_q == G_LD)
                        ld_data_d = zext(bus.eng_rdata, eng_len_q);
                    if_done_d = (grant_q == G_IF);
                    ld_done_d = (grant_q == G_LD);
                    st_done_d = (grant_q == G_ST);
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                grant_d = G_NONE;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = G_NONE;
                state_d = S_IDLE;
            end
        endcase
    end

    // rdy_in low freezes every register, so any pulse in flight is stretched.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            grant_q     <= G_NONE;
            eng_valid_q <= 1'b0;
            eng_rw_q    <= 1'b0;
            eng_addr_q  <= '0;
            eng_len_q   <= '0;
            eng_wdata_q <= '0;
            eng_abort_q <= 1'b0;
            if_done_q   <= 1'b0;
            ld_done_q   <= 1'b0;
            st_done_q   <= 1'b0;
            ld_data_q   <= '0;
`ifdef ARB_AGE_EN
            starve_q    <= '0;
`endif
        end else if (bus.rdy_in) begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            eng_valid_q <= eng_valid_d;
            eng_rw_q    <= eng_rw_d;
            eng_addr_q  <= eng_addr_d;
            eng_len_q   <= eng_len_d;
            eng_wdata_q <= eng_wdata_d;
            eng_abort_q <= eng_abort_d;
            if_done_q   <= if_done_d;
            ld_done_q   <= ld_done_d;
            st_done_q   <= st_done_d;
            ld_data_q   <= ld_data_d;
`ifdef ARB_AGE_EN
            starve_q    <= starve_d;
`endif
        end
    end

    assign bus.eng_valid = eng_valid_q;
    assign bus.eng_rw    = eng_rw_q;
    assign bus.eng_addr  = eng_addr_q;
    assign bus.eng_len   = eng_len_q;
    assign bus.eng_wdata = eng_wdata_q;
    assign bus.eng_abort = eng_abort_q;
    assign bus.if_done   = if_done_q;
    assign bus.ld_done   = ld_done_q;
    assign bus.st_done   = st_done_q;
    assign bus.ld_data   = ld_data_q;
endmodule
